// File: rtl/vector_exec_unit.sv
// ---------------------------------------------------------------------------
// vector_exec_unit
//
// Small vector execution unit with a private vector register file (VRF).
// One instruction is accepted at a time. It runs for vlen_p/lanes_p EXEC
// cycles, handling lanes_p elements per cycle. It then holds the result
// flags in DONE until the consumer takes them with yumi_i.
//
// Ports
//   clk_i            rising-edge clock
//   reset_ni         asynchronous active-low reset; clears FSM, operands,
//                    flags and the whole VRF
//   v_i / ready_o    instruction valid / accept (ready only in IDLE)
//   op_i             opcode: ADD SUB AND OR XOR SPLAT ADDS NOP (0..7)
//   vd_i             destination vector register
//   vs1_i, vs2_i     source vector registers
//   scalar_i         scalar operand for SPLAT / ADDS
//   v_o / yumi_i     completion valid / consume
//   flag_overflow_o  signed overflow in any lane of any chunk
//   flag_zero_o      every written element was zero
//   flag_negative_o  some written element had its MSB set
//   dbg_addr_i       {vreg, elem} debug read address
//   dbg_data_o       combinational debug read of the VRF
// ---------------------------------------------------------------------------
module vector_exec_unit #(
    parameter int els_p    = 32,
    parameter int vlen_p   = 8,
    parameter int vdw_p    = 32,
    parameter int lanes_p  = 4,
    parameter int op_len_p = 3,
    localparam int VA = (els_p  > 1) ? $clog2(els_p)  : 1,
    localparam int EA = (vlen_p > 1) ? $clog2(vlen_p) : 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                v_i,
    output logic                ready_o,
    input  logic [op_len_p-1:0] op_i,
    input  logic [VA-1:0]       vd_i,
    input  logic [VA-1:0]       vs1_i,
    input  logic [VA-1:0]       vs2_i,
    input  logic [vdw_p-1:0]    scalar_i,
    output logic                v_o,
    input  logic                yumi_i,
    output logic                flag_overflow_o,
    output logic                flag_zero_o,
    output logic                flag_negative_o,
    input  logic [VA+EA-1:0]    dbg_addr_i,
    output logic [vdw_p-1:0]    dbg_data_o
);

    // Number of chunks (EXEC cycles) per instruction and the counter width.
    localparam int N  = vlen_p / lanes_p;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);
    localparam int MSB = vdw_p - 1;

    localparam logic [op_len_p-1:0] OP_ADD   = op_len_p'(0);
    localparam logic [op_len_p-1:0] OP_SUB   = op_len_p'(1);
    localparam logic [op_len_p-1:0] OP_AND   = op_len_p'(2);
    localparam logic [op_len_p-1:0] OP_OR    = op_len_p'(3);
    localparam logic [op_len_p-1:0] OP_XOR   = op_len_p'(4);
    localparam logic [op_len_p-1:0] OP_SPLAT = op_len_p'(5);
    localparam logic [op_len_p-1:0] OP_ADDS  = op_len_p'(6);
    localparam logic [op_len_p-1:0] OP_NOP   = op_len_p'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [CW-1:0]        chunk_q, chunk_d;
    logic [op_len_p-1:0]  op_q;
    logic [VA-1:0]        vd_q, vs1_q, vs2_q;
    logic [vdw_p-1:0]     scalar_q;
    logic                 ovf_q, zero_q, neg_q;
    logic [vdw_p-1:0]     vrf_q [els_p][vlen_p];

    logic                 accept;
    logic                 write_en;

    // Per-lane datapath signals for the current chunk.
    logic [EA-1:0]        elem  [lanes_p];
    logic [vdw_p-1:0]     opa   [lanes_p];
    logic [vdw_p-1:0]     opb   [lanes_p];
    logic [vdw_p-1:0]     res   [lanes_p];
    logic                 chunk_ovf, chunk_neg, chunk_zero;

    assign accept   = v_i && (state_q == S_IDLE);
    assign write_en = (state_q == S_EXEC) && (op_q != OP_NOP);

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d = state_q;
        chunk_d = chunk_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    chunk_d = '0;
                end
            end
            S_EXEC: begin
                if (chunk_q == LAST_CHUNK) begin
                    state_d = S_DONE;
                    chunk_d = '0;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            S_DONE: begin
                if (yumi_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                chunk_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Lane datapath. All reads of a chunk come from vrf_q before the edge
    // that writes that chunk back, so vd aliasing vs1/vs2 is harmless.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [vdw_p-1:0] sum;
        logic [vdw_p-1:0] diff;
        logic             lane_ovf;

        chunk_ovf  = 1'b0;
        chunk_neg  = 1'b0;
        chunk_zero = 1'b1;
        sum        = '0;
        diff       = '0;
        lane_ovf   = 1'b0;

        for (int l = 0; l < lanes_p; l++) begin
            elem[l] = EA'(int'(chunk_q) * lanes_p + l);
            opa[l]  = vrf_q[vs1_q][elem[l]];
            opb[l]  = (op_q == OP_ADDS) ? scalar_q : vrf_q[vs2_q][elem[l]];
            sum     = opa[l] + opb[l];
            diff    = opa[l] - opb[l];
            res[l]  = '0;
            lane_ovf = 1'b0;

            unique case (op_q)
                OP_ADD, OP_ADDS: begin
                    res[l]   = sum;
                    // Same-sign operands producing an opposite-sign result.
                    lane_ovf = (opa[l][MSB] == opb[l][MSB]) && (sum[MSB] != opa[l][MSB]);
                end
                OP_SUB: begin
                    res[l]   = diff;
                    // Opposite-sign operands where the result flips sign from vs1.
                    lane_ovf = (opa[l][MSB] != opb[l][MSB]) && (diff[MSB] != opa[l][MSB]);
                end
                OP_AND:   res[l] = opa[l] & opb[l];
                OP_OR:    res[l] = opa[l] | opb[l];
                OP_XOR:   res[l] = opa[l] ^ opb[l];
                OP_SPLAT: res[l] = scalar_q;
                default:  res[l] = '0;
            endcase

            if (op_q != OP_NOP) begin
                chunk_ovf  = chunk_ovf | lane_ovf;
                chunk_neg  = chunk_neg | res[l][MSB];
                chunk_zero = chunk_zero & (res[l] == '0);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state, operand latches, flag accumulators and VRF
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= S_IDLE;
            chunk_q  <= '0;
            op_q     <= '0;
            vd_q     <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            scalar_q <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            // NOTE: the register file is cleared by reset on purpose, since
            // software relies on every vector reading zero after reset. This
            // keeps the VRF in flops rather than a RAM macro.
            for (int r = 0; r < els_p; r++) begin
                for (int e = 0; e < vlen_p; e++) begin
                    vrf_q[r][e] <= '0;
                end
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples pre-edge values, which the aliasing relies on.
            state_q <= state_d;
            chunk_q <= chunk_d;

            if (accept) begin
                op_q     <= op_i;
                vd_q     <= vd_i;
                vs1_q    <= vs1_i;
                vs2_q    <= vs2_i;
                scalar_q <= scalar_i;
                // Accumulators start neutral; NOP leaves them untouched.
                ovf_q    <= 1'b0;
                zero_q   <= 1'b1;
                neg_q    <= 1'b0;
            end

            if (write_en) begin
                ovf_q  <= ovf_q  | chunk_ovf;
                neg_q  <= neg_q  | chunk_neg;
                zero_q <= zero_q & chunk_zero;
                for (int l = 0; l < lanes_p; l++) begin
                    vrf_q[vd_q][elem[l]] <= res[l];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ready_o         = (state_q == S_IDLE);
    assign v_o             = (state_q == S_DONE);
    assign flag_overflow_o = ovf_q;
    assign flag_zero_o     = zero_q;
    assign flag_negative_o = neg_q;
    assign dbg_data_o      = vrf_q[dbg_addr_i[VA+EA-1:EA]][dbg_addr_i[EA-1:0]];

endmodule

// File: doc/vector_exec_unit.md
VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

Interface
REQ-001 The block SHALL have the following parameters:
- els_p, default 32, number of vector registers.
- vlen_p, default 8, elements per vector; a power of two.
- vdw_p, default 32, bits per element.
- lanes_p, default 4, elements processed per cycle; a power of two that divides vlen_p.
- op_len_p, default 3, opcode width.
REQ-002 Derived widths: VA = clog2(els_p), EA = clog2(vlen_p), both safe-clog2 (minimum 1).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- v_i  in  1  instruction valid.
- ready_o  out  1  instruction accept.
- op_i  in  op_len_p  opcode.
- vd_i  in  VA  destination register.
- vs1_i  in  VA  source register 1.
- vs2_i  in  VA  source register 2.
- scalar_i  in  vdw_p  scalar operand.
- v_o  out  1  completion valid.
- yumi_i  in  1  completion consume.
- flag_overflow_o  out  1  signed overflow on any element.
- flag_zero_o  out  1  all written elements are zero.
- flag_negative_o  out  1  any written element has MSB set.
- dbg_addr_i  in  VA+EA  debug read address {vreg, elem}.
- dbg_data_o  out  vdw_p  debug read data, combinational.

Function
REQ-004 Internal VRF SHALL hold els_p x vlen_p elements of vdw_p bits, with lanes_p read pairs and lanes_p write ports per cycle.
REQ-005 FSM states SHALL be IDLE, EXEC, and DONE.
REQ-006 ready_o SHALL be 1 only in IDLE.
REQ-007 An instruction SHALL be accepted on a rising edge when v_i && ready_o; op, vd, vs1, vs2 and scalar are latched, the chunk counter is cleared, and the FSM goes IDLE -> EXEC.
REQ-008 EXEC SHALL last exactly N = vlen_p/lanes_p cycles. In chunk c it reads elements c*lanes_p .. c*lanes_p+lanes_p-1 of vs1 and vs2, computes per lane, and writes the same indices of vd at that clock edge.
REQ-009 After chunk N-1 the FSM SHALL go EXEC -> DONE. v_o SHALL be 1 exactly in DONE, i.e. N+1 cycles after the accept edge.
REQ-010 In DONE, yumi_i SHALL move the FSM to IDLE on the next edge. Flags SHALL hold stable while v_o is 1. yumi_i outside DONE SHALL be ignored.
REQ-011 Opcodes:
- 0 ADD: vs1+vs2.
- 1 SUB: vs1-vs2.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SPLAT: scalar.
- 6 ADDS: vs1+scalar.
- 7 NOP: no VRF write; still runs N EXEC cycles; flags report zero=1, negative=0, overflow=0.
REQ-012 Arithmetic SHALL be modulo 2^vdw_p (wrap-around). Overflow is signed two's-complement overflow of ADD, SUB, or ADDS in any lane of any chunk. It is always 0 for logic ops and SPLAT.
REQ-013 Flags SHALL accumulate across all chunks of one instruction:
- overflow = OR over lanes and chunks.
- negative = OR of result MSBs.
- zero = AND of (result == 0).
- Accumulators initialise at the accept edge.
REQ-014 vd equal to vs1 and/or vs2 SHALL be legal. Each chunk reads pre-write values of its own indices, so the result equals the non-aliased computation.
REQ-015 dbg_data_o SHALL reflect VRF contents as of the last completed clock edge. A write in cycle t is visible from cycle t+1.
REQ-016 v_i asserted while ready_o=0 SHALL have no effect; the instruction is not queued.
REQ-017 Any vd/vs index >= els_p SHALL be masked to VA bits, i.e. taken modulo 2^VA.

Reset
REQ-018 While reset_ni=0 the block SHALL immediately, without waiting for a clock edge: set the FSM to IDLE, drive ready_o=1, v_o=0, all flags 0, clear the chunk counter and latched operands, and clear all VRF elements to 0.
REQ-019 Reset during EXEC or DONE SHALL abort the instruction. No further writes occur, and the first accept after reset deasserts behaves as a fresh start.

Verification
REQ-020 SPLAT then read: SPLAT vd=3, scalar=0x0000_00A5 -> v_o is 1 on cycle 3 after accept (defaults), all 8 dbg reads of vreg 3 return 0xA5, zero=0, negative=0, overflow=0.
REQ-021 ADD overflow: splat v1=0x7FFF_FFFF and v2=0x1, then ADD vd=4 -> every element of v4 = 0x8000_0000, overflow=1, negative=1, zero=0.
REQ-022 SUB self-alias: v5=splat 0x1234, then SUB vd=5, vs1=5, vs2=5 -> v5 all 0, zero=1, overflow=0.
REQ-023 Handshake: hold yumi_i=0 for 5 cycles in DONE -> v_o and flags stable, ready_o=0, and v_i pulses during this time are ignored. yumi_i=1 -> ready_o=1 next cycle.
REQ-024 Reset mid-EXEC: SPLAT 0xFF to v2, assert reset_ni=0 after the first EXEC cycle -> ready_o=1 and v_o=0 immediately, all dbg reads return 0.
REQ-025 Parameter sweep with lanes_p=1, 2, 8 and vlen_p=8 -> EXEC lasts 8, 4, 1 cycles respectively, with results identical to the default configuration.
